// File: rtl/rs_age_issue_queue.sv
// rs_age_issue_queue: age-ordered ALU reservation station with multi-channel CDB wakeup and a registered issue slot
module rs_age_issue_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN = 32,
  parameter int TAG_W = 4,
  parameter int OP_W = 5,
  parameter int NUM_CDB = 2,
  localparam int AGE_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     stall,
  input  logic                     in_valid,
  input  logic [OP_W-1:0]          in_op,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     in_q1_wait,
  input  logic                     in_q2_wait,
  input  logic [TAG_W-1:0]         in_q1,
  input  logic [TAG_W-1:0]         in_q2,
  input  logic [XLEN-1:0]          in_v1,
  input  logic [XLEN-1:0]          in_v2,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
  output logic                     full,
  output logic [AGE_W:0]           count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OP_W-1:0]          out_op,
  output logic [TAG_W-1:0]         out_tag,
  output logic [XLEN-1:0]          out_v1,
  output logic [XLEN-1:0]          out_v2
);
  logic [DEPTH-1:0] busy, w1, w2, ready;
  logic [OP_W-1:0] op [DEPTH];
  logic [TAG_W-1:0] tag [DEPTH];
  logic [TAG_W-1:0] q1 [DEPTH];
  logic [TAG_W-1:0] q2 [DEPTH];
  logic [XLEN-1:0] v1 [DEPTH];
  logic [XLEN-1:0] v2 [DEPTH];
  logic [AGE_W-1:0] age [DEPTH];
  logic [XLEN:0] wk1 [DEPTH];
  logic [XLEN:0] wk2 [DEPTH];
  logic [XLEN:0] in_wk1, in_wk2;
  logic [AGE_W-1:0] ins_idx, sel_idx, sel_age;
  logic ins, iss, any_ready, slot_free;
  // Returns {wait, value}; channels scanned high to low so the lowest matching channel wins.
  function automatic logic [XLEN:0] wake(
    input logic w,
    input logic [TAG_W-1:0] q,
    input logic [XLEN-1:0] v,
    input logic [NUM_CDB-1:0] cv,
    input logic [NUM_CDB*TAG_W-1:0] ct,
    input logic [NUM_CDB*XLEN-1:0] cd
  );
    logic [XLEN:0] r;
    r = {w, v};
    for (int k = NUM_CDB - 1; k >= 0; k--)
      if (w && cv[k] && ct[k*TAG_W +: TAG_W] == q) r = {1'b0, cd[k*XLEN +: XLEN]};
    return r;
  endfunction
  assign full = &busy;
  assign ready = busy & ~w1 & ~w2;
  assign any_ready = |ready;
  assign slot_free = !out_valid || out_ready;
  assign ins = rdy && !rst && !flush && !stall && in_valid && !full;
  assign iss = rdy && !rst && !flush && slot_free && any_ready;
  assign in_wk1 = wake(in_q1_wait, in_q1, in_v1, cdb_valid, cdb_tag, cdb_data);
  assign in_wk2 = wake(in_q2_wait, in_q2, in_v2, cdb_valid, cdb_tag, cdb_data);
  // Busy ages are unique, so the first ready entry with the highest age is the oldest.
  always_comb begin
    ins_idx = '0;
    sel_idx = '0;
    sel_age = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i]) ins_idx = AGE_W'(i);
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i] = wake(w1[i], q1[i], v1[i], cdb_valid, cdb_tag, cdb_data);
      wk2[i] = wake(w2[i], q2[i], v2[i], cdb_valid, cdb_tag, cdb_data);
      if (ready[i] && age[i] >= sel_age) begin
        sel_idx = AGE_W'(i);
        sel_age = age[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst || flush) begin
        busy <= '0;
        out_valid <= 1'b0;
        count <= '0;
        if (rst) begin
          out_op <= '0;
          out_tag <= '0;
          out_v1 <= '0;
          out_v2 <= '0;
          for (int i = 0; i < DEPTH; i++) age[i] <= '0;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          {w1[i], v1[i]} <= wk1[i];
          {w2[i], v2[i]} <= wk2[i];
          age[i] <= age[i] - AGE_W'(iss && age[i] > sel_age) + AGE_W'(ins);
        end
        if (iss) busy[sel_idx] <= 1'b0;
        if (ins) begin
          busy[ins_idx] <= 1'b1;
          op[ins_idx] <= in_op;
          tag[ins_idx] <= in_tag;
          q1[ins_idx] <= in_q1;
          q2[ins_idx] <= in_q2;
          {w1[ins_idx], v1[ins_idx]} <= in_wk1;
          {w2[ins_idx], v2[ins_idx]} <= in_wk2;
          age[ins_idx] <= '0;
        end
        count <= count + (AGE_W + 1)'(ins) - (AGE_W + 1)'(iss);
        if (slot_free) begin
          out_valid <= any_ready;
          if (any_ready) begin
            out_op <= op[sel_idx];
            out_tag <= tag[sel_idx];
            out_v1 <= v1[sel_idx];
            out_v2 <= v2[sel_idx];
          end
        end
      end
    end
  end
endmodule

// File: doc/rs_age_issue_queue.md
# rs_age_issue_queue

Parametrised, age-ordered reservation station for the integer ALU path. It buffers up to DEPTH decoded ALU/branch µops tagged with ROB ids and captures missing operands from NUM_CDB result broadcast channels, including same-cycle bypass at insertion. Each cycle it issues the oldest operand-complete entry to the ALU through a registered valid/ready output stage. It sits between decoder/RF/ROB dispatch and the ALU, replacing the fixed-size, lowest-index-first, single-wakeup station.

## Interface
- DEPTH, 8: number of entries (≥2, power of two); AGE_W = log2(DEPTH)
- XLEN, 32: operand width
- TAG_W, 4: ROB id width
- OP_W, 5: ALU opcode width, carried opaquely
- NUM_CDB, 2: number of wakeup broadcast channels
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset; takes effect only when rdy=1
- rdy  in  1  global enable; rdy=0 freezes all state
- flush  in  1  misprediction squash
- stall  in  1  blocks insertion only
- in_valid  in  1  dispatch request
- in_op  in  OP_W  ALU op
- in_tag  in  TAG_W  ROB id of the µop
- in_q1_wait / in_q2_wait  in  1  operand still pending
- in_q1 / in_q2  in  TAG_W  producer ROB id when pending
- in_v1 / in_v2  in  XLEN  operand value when not pending (imm for I-type, supplied by dispatch)
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_tag  in  NUM_CDB*TAG_W  channel k at bits [k*TAG_W +: TAG_W]
- cdb_data  in  NUM_CDB*XLEN  channel k at bits [k*XLEN +: XLEN]
- full  out  1  combinational; all DEPTH entries busy
- count  out  AGE_W+1  registered number of busy entries
- out_valid  out  1  issue slot holds a µop
- out_ready  in  1  ALU accepts the slot this cycle
- out_op / out_tag  out  OP_W / TAG_W  issued µop
- out_v1 / out_v2  out  XLEN  issued operands

## Operation
- Per-entry state: busy, op, tag, w1/q1/v1, w2/q2/v2, age[AGE_W].
- Insert accepted iff rdy & !rst & !flush & !stall & in_valid & !full. Target is the lowest-index free entry. Age is 0. Each pending operand is first checked against all valid CDB channels. On a match it is stored resolved with that channel's data.
- Wakeup: for every busy entry and every valid channel k, a pending operand whose q equals cdb_tag[k] clears w and takes cdb_data[k]. If several channels match, the lowest k wins.
- Ready entry: busy & !w1 & !w2, evaluated on registered state. Wakeups and inserts made at an edge are visible from the next cycle.
- Issue slot free: !out_valid | out_ready. When the slot is free and at least one entry is ready, the ready entry with the largest age loads out_*. That entry's busy clears and out_valid becomes 1. When the slot is free and no entry is ready, out_valid becomes 0. When the slot is not free, out_* hold unchanged.
- Age update on each edge, with R the removed entry's age if an issue occurs:
  - A remaining busy entry with age > R decrements.
  - Every remaining busy entry increments if an insert occurs.
  - Both adjustments apply in the same cycle when both events occur.
  - Ages of busy entries are therefore always unique and lie in 0..count-1.
- flush: clears all busy bits and out_valid and sets count=0. It overrides insert and issue in the same cycle. CDB inputs are ignored that cycle.
- rst: same as flush, and additionally zeroes out_op, out_tag, out_v1, out_v2 and all ages.

## Timing
- Reset values: full=0, count=0, out_valid=0, out_op=0, out_tag=0, out_v1=0, out_v2=0.
- Minimum latency: a µop inserted ready at edge E0 appears on out_valid after E1, giving 1 cycle of residency.
- A CDB hit at edge E makes the entry issuable at E+1 at the earliest.
- Backpressure: while out_valid=1 and out_ready=0, the outputs stay stable and no entry leaves. Queue contents still accept inserts and wakeups.
- full=1: in_valid is ignored with no state change. An issue in the same cycle does not free a slot for that cycle's insert.
- Insert and issue in the same cycle: count is unchanged and ages follow the combined rule.
- Back-to-back issue at 1 per cycle while out_ready=1 and ready entries remain.
- rdy=0: no state change, including during flush or rst assertion.

## Test plan
- Reset then single op: insert op=3, tag=5, v1=10, v2=20 with both operands resolved. Expect out_valid=1 exactly 1 cycle later with tag=5, v1=10, v2=20. count goes 0→1→0.
- Age order: insert tag 1 (w1, q1=7), then tags 2 and 3 resolved. Broadcast tag 7 with data 0xAB on channel 1. Issue order must be 2, 3, 1, with tag 1 carrying v1=0xAB.
- Insert bypass: insert with in_q2_wait=1, q2=4 in the same cycle that cdb_valid[0]=1, tag 4, data 99. Entry issues next cycle with v2=99 and no further broadcast.
- Dual CDB: two entries wait on tags 2 and 6. Broadcast both tags in one cycle on channels 0 and 1. Both entries become ready and issue oldest first on consecutive cycles.
- Backpressure/full: hold out_ready=0 and fill DEPTH entries. Expect full=1, count=DEPTH, and out_* stable. A further in_valid causes no change. Release out_ready and observe one issue per cycle with full dropping after the first.
- Flush mid-stream: with 5 busy entries and out_valid=1, assert flush together with in_valid and a CDB hit. Next cycle count=0, out_valid=0, full=0, and nothing issues afterward.
